pattern_loader: RTL

PATTERN_LOADER -- requirements
Module: pattern_loader

---
 rtl/pattern_loader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pattern_loader.sv
// rtl/pattern_loader.sv - streams a stored tile pattern (or zeros) into an array, one handshaked write per tile
module pattern_loader #(
  parameter int TILE_W       = 16,
  parameter int NUM_TILES    = 4,
  parameter int NUM_PATTERNS = 2,
  parameter logic [NUM_PATTERNS*NUM_TILES*TILE_W-1:0] PATTERN_INIT =
    128'h0000_0000_0000_0000_033E_0886_0000_6E88,
  localparam int POS_W = ($clog2(NUM_TILES) > 1) ? $clog2(NUM_TILES) : 1,
  localparam int SEL_W = ($clog2(NUM_PATTERNS) > 1) ? $clog2(NUM_PATTERNS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              debug,
  input  logic [SEL_W-1:0]  pattern_sel,
  input  logic              clear,
  input  logic              write_ready,
  output logic [POS_W-1:0]  pos,
  output logic [TILE_W-1:0] val,
  output logic              write_enb,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [POS_W-1:0] LAST_IDX = POS_W'(NUM_TILES - 1);

  state_e              state_q, state_d;
  logic [POS_W-1:0]    idx_q, idx_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                clr_q, clr_d;
  logic [TILE_W-1:0]   val_q, val_d;
  logic                we_q, we_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                debug_q;
  logic                trigger;

  function automatic logic [TILE_W-1:0] tile_value(input logic [SEL_W-1:0] s,
                                                   input logic [POS_W-1:0] i);
    return PATTERN_INIT[(int'(s) * NUM_TILES + int'(i)) * TILE_W +: TILE_W];
  endfunction

  assign trigger = debug & ~debug_q;

  // State, write-presentation and edge-detect registers; reset aborts any load in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sel_q   <= '0;
      clr_q   <= 1'b0;
      val_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      debug_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      clr_q   <= clr_d;
      val_q   <= val_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      debug_q <= debug;
    end
  end

  // Next state: latch the request on trigger, advance one tile per accepted write, pulse done.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    clr_d   = clr_q;
    val_d   = val_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        we_d   = 1'b0;
        if (trigger) begin
          sel_d   = (int'(pattern_sel) >= NUM_PATTERNS) ? '0 : pattern_sel;
          clr_d   = clear;
          idx_d   = '0;
          val_d   = clear ? '0 : tile_value(sel_d, '0);
          we_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (we_q && write_ready) begin
          if (idx_q == LAST_IDX) begin
            we_d    = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
            val_d = clr_q ? '0 : tile_value(sel_q, idx_d);
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign pos       = idx_q;
  assign val       = val_q;
  assign write_enb = we_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
